// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg: shared UART types, oversampling constant and baud helper.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int OVERSAMPLE = 16;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// +--------------------------------------------------------------------------+
// | baud_tick_gen: single-cycle tick every DIV clocks, restarted by clear.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int                c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // First tick lands DIV clocks after clear, so a bit lasts exactly 16*DIV.
  assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// +--------------------------------------------------------------------------+
// | fifo_uart_tx: pops bytes from a FWFT FIFO and sends them as 8N1 UART.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int c_DIV = baud_div(CLK_FREQ, BAUD);

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [2:0]            r_bit_idx;
  logic [3:0]            r_tick_cnt;
  logic                  r_tx;
  logic                  r_done;
  logic                  w_pop;
  logic                  w_tick;

  assign w_pop   = rst && (r_state == IDLE) && !fifo_empty;
  assign fifo_re = w_pop;
  assign tx_busy = (r_state != IDLE) || w_pop;
  assign tx      = r_tx;
  assign tx_done = r_done;

  baud_tick_gen #(
    .DIV (c_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_pop),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= 3'd0;
      r_tick_cnt <= 4'd0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift    <= fifo_rdata;
            r_bit_idx  <= 3'd0;
            r_tick_cnt <= 4'd0;
            r_tx       <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_bit_idx <= 3'd0;
              r_tx      <= r_shift[0];
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              // Drive the next line level together with the shift so tx stays registered.
              if (r_bit_idx == 3'd7) begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end else begin
                r_tx <= r_shift[1];
              end
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// +--------------------------------------------------------------------------+
// | tb_fifo_uart_tx: scoreboard bench with a FIFO model and a line decoder.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_uart_tx;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = 64;
  localparam int FRAME    = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_re;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int re_count = 0;
  int done_count = 0;
  int frames   = 0;
  int n_sent   = 0;
  bit mon_busy = 1'b0;

  logic [7:0] q_fifo[$];
  logic [7:0] exp_q[$];

  fifo_uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void refresh();
    fifo_empty = (q_fifo.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : q_fifo[0];
  endfunction

  task automatic push(input logic [7:0] b);
    q_fifo.push_back(b);
    exp_q.push_back(b);
    n_sent++;
    refresh();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO model: first-word-fall-through, popped on a sampled read strobe.
  initial begin
    logic re_s;
    forever begin
      @(negedge clk);
      re_s = fifo_re;
      if (fifo_re === 1'b1) re_count++;
      @(posedge clk);
      #1;
      if (re_s === 1'b1 && q_fifo.size() > 0) void'(q_fifo.pop_front());
      refresh();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_count++;
    end
  end

  // Line decoder: samples mid-bit and scores each complete frame.
  initial begin
    logic [9:0] bits;
    bit aborted;
    bit early_done;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 || tx !== 1'b0) continue;
      mon_busy   = 1'b1;
      aborted    = 1'b0;
      early_done = 1'b0;
      bits       = '0;
      for (int o = 0; o <= FRAME; o++) begin
        if (o > 0) @(negedge clk);
        if (rst !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (o >= BIT / 2 && o <= BIT / 2 + 9 * BIT && ((o - BIT / 2) % BIT) == 0)
          bits[(o - BIT / 2) / BIT] = tx;
        if (o < FRAME && tx_done === 1'b1) early_done = 1'b1;
      end
      if (!aborted) begin
        frames++;
        check("start_bit", {31'd0, bits[0]}, 32'd0);
        check("stop_bit", {31'd0, bits[9]}, 32'd1);
        check("done_at_640", {31'd0, tx_done}, 32'd1);
        check("no_early_done", {31'd0, early_done}, 32'd0);
        check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
      end
      mon_busy = 1'b0;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_busy !== 1'b0) && n < budget) begin
      step(1);
      n++;
    end
    check("drain_in_budget", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic wait_fall(output int t, input int budget);
    logic prev;
    prev = tx;
    t = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        t = cyc;
        break;
      end
      prev = tx;
    end
    check("fall_in_budget", {31'd0, t >= 0}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, r0, d0, viol, n, early;
    refresh();
    rst = 1'b0;
    step(5);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    check("reset_re", {31'd0, fifo_re}, 32'd0);
    rst = 1'b1;
    step(3);

    // Single byte 0xA5.
    r0 = re_count;
    push(8'hA5);
    wait_idle(2000);
    check("single_pops", r0 + 1, re_count);

    // Back-to-back 0x00 then 0xFF.
    r0 = re_count;
    push(8'h00);
    push(8'hFF);
    wait_fall(t1, 100);
    wait_fall(t2, 1000);
    check("b2b_spacing", t2 - t1, 641);
    step(1);
    wait_idle(2000);
    check("b2b_pops", re_count - r0, 2);

    // Empty FIFO keeps the line idle.
    viol = 0;
    repeat (2000) begin
      @(negedge clk);
      if (fifo_re !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) viol++;
    end
    check("empty_idle_violations", viol, 0);
    step(1);

    // Reset during data bit 3 of 0x3C.
    d0 = done_count;
    push(8'h3C);
    wait_fall(t1, 100);
    repeat (280) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    check("abort_not_busy", {31'd0, tx_busy}, 32'd0);
    void'(exp_q.pop_front());
    n_sent--;
    step(3);
    rst = 1'b1;
    r0 = re_count;
    repeat (800) @(negedge clk);
    check("abort_no_done", done_count - d0, 0);
    check("abort_no_repop", re_count - r0, 0);
    step(1);

    // Reset held while the FIFO is non-empty.
    rst = 1'b0;
    push(8'h5A);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_re !== 1'b0) viol++;
    end
    check("reset_blocks_pop", viol, 0);
    step(1);
    rst = 1'b1;
    wait_idle(2000);

    // Data arriving during the stop bit waits for the first IDLE cycle.
    push(8'h81);
    wait_fall(t1, 100);
    repeat (600) @(negedge clk);
    @(posedge clk);
    #2;
    push(8'h7E);
    n = 0;
    early = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (tx_done === 1'b1) break;
      if (fifo_re === 1'b1) early++;
    end
    check("late_no_early_pop", early, 0);
    check("late_done_seen", {31'd0, tx_done}, 32'd1);
    check("late_pop_with_done", {31'd0, fifo_re}, 32'd1);
    step(1);
    wait_idle(2000);

    // Random bytes with random gaps.
    for (int i = 0; i < 8; i++) begin
      push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) != 0) step($urandom_range(1, 1500));
    end
    wait_idle(20000);

    check("done_count", done_count, n_sent);
    check("frames_decoded", frames, n_sent);
    check("fifo_drained", q_fifo.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
